ps2_receptor: RTL and testbench

PS/2 keyboard front end: samples the raw keyboard clock and data lines, filters them and deserialises each 11-bit frame. Each frame is checked for start, odd parity and stop, and the scan code is presented as DATO with a one-cycle flag.
Sits directly upstream of the Recep command interpreter, which consumes DATO/flag (e.g. 5A, 16, 3E, 33, 1C, 2D).
One clock domain (CLK, 100 MHz on Nexys 3).

---
 rtl/ps2_receptor.sv | 156 +++++++++++++++
 tb/tb_ps2_receptor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ps2_receptor.sv
// PS/2 keyboard receiver: synchronises and deglitches ps2clk/ps2data, then checks and decodes 11-bit frames.
// Optional build macro PS2_BREAK_FILTER_EN hides key-release sequences (F0 xx) from the consumer.
module ps2_receptor #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] DATO,
    output logic       flag,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

    state_t                state, state_nx;
    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt;
    logic                  fclk;
    logic                  fall_edge;
    logic [3:0]            bcnt;
    logic [9:0]            sh;
    logic [TW-1:0]         to_cnt;
    logic                  timeout;
    logic                  last_bit;
    logic                  frame_ok;
`ifdef PS2_BREAK_FILTER_EN
    logic                  break_pending;
`endif

    // Both lines idle high, so the synchronisers come out of reset at 1.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2data;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            filt <= '1;
            fclk <= 1'b1;
        end else begin
            filt <= {filt[FILTER_LEN-2:0], clk_s2};
            if (filt == '0)
                fclk <= 1'b0;
            else if (filt == '1)
                fclk <= 1'b1;
        end
    end

    // Edge fires the same cycle the window becomes all-zero, one cycle ahead of fclk.
    assign fall_edge = fclk && (filt == '0);

    assign timeout  = (state == RX) && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign last_bit = fall_edge && (bcnt == 4'd9);
    assign frame_ok = sh[9] && (^sh[8:0]);
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fall_edge && !dat_s2) state_nx = RX;
            RX: begin
                if (timeout)
                    state_nx = IDLE;
                else if (last_bit)
                    state_nx = CHECK;
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame shifts in LSB first: after ten bits sh = {stop, parity, data[7:0]}.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            bcnt   <= '0;
            sh     <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                RX: begin
                    if (timeout) begin
                        bcnt   <= '0;
                        to_cnt <= '0;
                    end else if (fall_edge) begin
                        sh     <= {dat_s2, sh[9:1]};
                        bcnt   <= bcnt + 4'd1;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    bcnt   <= '0;
                    to_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            DATO       <= 8'h00;
            flag       <= 1'b0;
            parity_err <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            break_pending <= 1'b0;
`endif
        end else begin
            flag       <= 1'b0;
            parity_err <= 1'b0;
            if (state == CHECK) begin
                if (!frame_ok) begin
                    parity_err <= 1'b1;
                end else begin
`ifdef PS2_BREAK_FILTER_EN
                    // Swallow F0 and the release code that follows it.
                    if (sh[7:0] == 8'hF0) begin
                        break_pending <= 1'b1;
                    end else if (break_pending) begin
                        break_pending <= 1'b0;
                    end else begin
                        DATO <= sh[7:0];
                        flag <= 1'b1;
                    end
`else
                    DATO <= sh[7:0];
                    flag <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_receptor.sv
// Scoreboard bench for ps2_receptor: stimulus pushes expected flag/error events, a monitor pops and compares.
module tb_ps2_receptor;

    localparam int FL  = 8;
    localparam int TO  = 500;
    localparam int LAT = 2 + FL + 2;   // ps2clk fall of stop bit -> flag cycle

    logic       CLK = 1'b0;
    logic       reset;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] DATO;
    logic       flag;
    logic       parity_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit         err;
        logic [7:0] dato;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] last_good = 8'h00;

    ps2_receptor #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
        .DATO(DATO), .flag(flag), .parity_err(parity_err), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every flag or parity_err pulse must match the head of the queue.
    always @(negedge CLK) begin
        if (reset === 1'b0 && (flag === 1'b1 || parity_err === 1'b1)) begin
            chk("flag_and_err_exclusive", {31'd0, flag & parity_err}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_event", {30'd0, flag, parity_err}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_kind", {30'd0, flag, parity_err}, e.err ? 32'd1 : 32'd2);
                chk("event_dato", {24'd0, DATO}, {24'd0, e.dato});
                chk("event_latency", cyc, e.cyc);
                chk("busy_at_event", {31'd0, busy}, 32'd0);
            end
        end
    end

    // exp: 0 = no event, 1 = flag with d, 2 = parity_err with DATO unchanged
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                              input int nbits, input bit glitch, input int exp);
        logic [10:0] fr;
        exp_t        e;
        fr = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < 20; j++) begin
                @(negedge CLK);
                if (j == 0) ps2data = fr[i];
                ps2clk = (glitch && j >= 3 && j < 9) ? 1'b0 : 1'b1;
            end
            @(negedge CLK);
            ps2clk = 1'b0;
            if (i == 10 && exp != 0) begin
                e.err  = (exp == 2);
                e.dato = (exp == 1) ? d : last_good;
                e.cyc  = cyc + LAT;
                q.push_back(e);
                if (exp == 1) last_good = d;
            end
            repeat (20) @(negedge CLK);
            ps2clk = 1'b1;
        end
        repeat (30) @(negedge CLK);
    endtask

    task automatic idle_glitches();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK) ps2clk = 1'b0;
            repeat (5) @(negedge CLK);
            ps2clk = 1'b1;
            repeat (20) @(negedge CLK);
        end
    endtask

    initial begin
        repeat (80000) @(posedge CLK);
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_dato", {24'd0, DATO}, 32'h00);
        chk("reset_flags", {29'd0, flag, parity_err, busy}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge CLK);

        send_frame(8'h5A, 0, 1, 11, 0, 1);
        send_frame(8'h16, 0, 1, 11, 0, 1);
        chk("dato_16", {24'd0, DATO}, 32'h16);

        send_frame(8'h3E, 1, 1, 11, 0, 2);
        send_frame(8'h33, 0, 0, 11, 0, 2);
        chk("dato_held_after_errs", {24'd0, DATO}, 32'h16);

        // Abandoned frame: start + 4 data bits, then silence.
        send_frame(8'h1C, 0, 1, 5, 0, 0);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        repeat (600) @(negedge CLK);
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);
        send_frame(8'h1C, 0, 1, 11, 0, 1);
        chk("dato_1c", {24'd0, DATO}, 32'h1C);

        idle_glitches();
        chk("busy_after_idle_glitch", {31'd0, busy}, 32'd0);
        send_frame(8'h2D, 0, 1, 11, 1, 1);
        chk("dato_2d_glitched", {24'd0, DATO}, 32'h2D);

`ifdef PS2_BREAK_FILTER_EN
        send_frame(8'hF0, 0, 1, 11, 0, 0);
        send_frame(8'h1C, 0, 1, 11, 0, 0);
        chk("dato_after_break", {24'd0, DATO}, 32'h2D);
`else
        send_frame(8'hF0, 0, 1, 11, 0, 1);
        chk("dato_f0", {24'd0, DATO}, 32'hF0);
        send_frame(8'h1C, 0, 1, 11, 0, 1);
        chk("dato_release_1c", {24'd0, DATO}, 32'h1C);
`endif
        send_frame(8'h2D, 0, 1, 11, 0, 1);
        chk("dato_2d_final", {24'd0, DATO}, 32'h2D);

        // Reset in the middle of a frame.
        send_frame(8'h5A, 0, 1, 5, 0, 0);
        @(negedge CLK) reset = 1'b1;
        #1;
        chk("midreset_dato", {24'd0, DATO}, 32'h00);
        chk("midreset_flags", {29'd0, flag, parity_err, busy}, 32'd0);
        last_good = 8'h00;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        repeat (20) @(negedge CLK);
        send_frame(8'h16, 0, 1, 11, 0, 1);
        chk("dato_16_after_reset", {24'd0, DATO}, 32'h16);

        repeat (50) @(negedge CLK);
        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
